zigzag_seq: RTL and testbench

Job sequencer for the zig-zag address generation unit. It accepts a bit-serial multiply job (weight/data precisions, tile count, base addresses, strides) and drives the AGU's `step`/`clr` inputs. It combines the AGU's `offw`/`offd` offsets with per-tile base addresses to produce weight and data memory read addresses. It also emits accumulator framing strobes and sits between the job-issue logic and the AGU/memory/shift-accumulator datapath.

---
 rtl/zigzag_seq.sv | 179 +++++++++++++++++
 tb/tb_zigzag_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_seq.sv
// Job sequencer for the zig-zag AGU: walks ntile tiles of pw*pd steps, drives step/clr,
// forms per-tile read addresses and registered accumulator framing strobes.
module zigzag_seq #(
  parameter int unsigned BWADDR = 21,
  parameter int unsigned BWCNT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  input  logic [3:0]        pw,
  input  logic [3:0]        pd,
  input  logic [BWCNT-1:0]  ntile,
  input  logic [BWADDR-1:0] wbase,
  input  logic [BWADDR-1:0] dbase,
  input  logic [BWADDR-1:0] wstride,
  input  logic [BWADDR-1:0] dstride,
  input  logic              zz_sh,
  input  logic [3:0]        zz_offw,
  input  logic [3:0]        zz_offd,
  output logic              zz_step,
  output logic              zz_clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BWADDR-1:0] waddr,
  output logic [BWADDR-1:0] daddr,
  output logic              addr_vld,
  output logic              acc_clr,
  output logic              acc_last,
  output logic              acc_sh
);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        p_q, p_d;
  logic [7:0]        stepcnt_q, stepcnt_d;
  logic [BWCNT-1:0]  ntile_q, ntile_d;
  logic [BWCNT-1:0]  tile_q, tile_d;
  logic [BWADDR-1:0] wstride_q, wstride_d;
  logic [BWADDR-1:0] dstride_q, dstride_d;
  logic [BWADDR-1:0] tw_q, tw_d;
  logic [BWADDR-1:0] td_q, td_d;
  logic              err_q, err_d;
  logic [BWADDR-1:0] waddr_q, waddr_d;
  logic [BWADDR-1:0] daddr_q, daddr_d;
  logic              addr_vld_q, addr_vld_d;
  logic              acc_clr_q, acc_clr_d;
  logic              acc_last_q, acc_last_d;
  logic              acc_sh_q, acc_sh_d;

  logic last_step, last_tile, bad_job;

  assign last_step = (stepcnt_q == (p_q - 8'd1));
  assign last_tile = (tile_q == (ntile_q - BWCNT'(1)));
  assign bad_job   = (pw == 4'd0) || (pd == 4'd0) || (ntile == '0);

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    stepcnt_d = stepcnt_q;
    ntile_d   = ntile_q;
    tile_d    = tile_q;
    wstride_d = wstride_q;
    dstride_d = dstride_q;
    tw_d      = tw_q;
    td_d      = td_q;
    err_d     = err_q;
    zz_step   = 1'b0;
    zz_clr    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          p_d       = {4'd0, pw} * {4'd0, pd};
          ntile_d   = ntile;
          wstride_d = wstride;
          dstride_d = dstride;
          tw_d      = wbase;
          td_d      = dbase;
          tile_d    = '0;
          stepcnt_d = '0;
          err_d     = bad_job;
          state_d   = bad_job ? StDone : StInit;
        end
      end
      StInit: begin
        busy    = 1'b1;
        zz_clr  = 1'b1;
        state_d = abort ? StIdle : StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (abort) begin
          zz_clr  = 1'b1;
          state_d = StIdle;
        end else if (!stall) begin
          zz_step   = 1'b1;
          stepcnt_d = stepcnt_q + 8'd1;
          if (last_step) begin
            // clr overrides step in the AGU, so the next tile restarts at (0,0) with no bubble
            zz_clr    = 1'b1;
            stepcnt_d = '0;
            tile_d    = tile_q + BWCNT'(1);
            tw_d      = tw_q + wstride_q;
            td_d      = td_q + dstride_q;
            if (last_tile) state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = !abort;
        zz_clr  = abort;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_vld_d = zz_step;
    acc_clr_d  = zz_step && (stepcnt_q == 8'd0);
    acc_last_d = zz_step && last_step;
    acc_sh_d   = zz_sh && zz_step;
    waddr_d    = zz_step ? tw_q + BWADDR'(zz_offw) : waddr_q;
    daddr_d    = zz_step ? td_q + BWADDR'(zz_offd) : daddr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      p_q        <= '0;
      stepcnt_q  <= '0;
      ntile_q    <= '0;
      tile_q     <= '0;
      wstride_q  <= '0;
      dstride_q  <= '0;
      tw_q       <= '0;
      td_q       <= '0;
      err_q      <= 1'b0;
      waddr_q    <= '0;
      daddr_q    <= '0;
      addr_vld_q <= 1'b0;
      acc_clr_q  <= 1'b0;
      acc_last_q <= 1'b0;
      acc_sh_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      stepcnt_q  <= stepcnt_d;
      ntile_q    <= ntile_d;
      tile_q     <= tile_d;
      wstride_q  <= wstride_d;
      dstride_q  <= dstride_d;
      tw_q       <= tw_d;
      td_q       <= td_d;
      err_q      <= err_d;
      waddr_q    <= waddr_d;
      daddr_q    <= daddr_d;
      addr_vld_q <= addr_vld_d;
      acc_clr_q  <= acc_clr_d;
      acc_last_q <= acc_last_d;
      acc_sh_q   <= acc_sh_d;
    end
  end

  assign err      = err_q;
  assign waddr    = waddr_q;
  assign daddr    = daddr_q;
  assign addr_vld = addr_vld_q;
  assign acc_clr  = acc_clr_q;
  assign acc_last = acc_last_q;
  assign acc_sh   = acc_sh_q;

endmodule

// File: tb/tb_zigzag_seq.sv
// Directed bench for zigzag_seq: a per-cycle vector table for the nominal job plus
// hand-written stall, abort, overlap, reject, wrap and async-reset sequences.
module tb_zigzag_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, stall = 1'b0;
  logic [3:0]  pw = 4'd2, pd = 4'd3;
  logic [15:0] ntile = 16'd2;
  logic [20:0] wbase = 21'h100, dbase = 21'h200, wstride = 21'h10, dstride = 21'h8;
  logic        zz_sh = 1'b0;
  logic [3:0]  zz_offw = 4'd0, zz_offd = 4'd0;
  logic        zz_step, zz_clr, busy, done, err, addr_vld, acc_clr, acc_last, acc_sh;
  logic [20:0] waddr, daddr;

  zigzag_seq #(.BWADDR(21), .BWCNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .pw(pw), .pd(pd), .ntile(ntile), .wbase(wbase), .dbase(dbase),
    .wstride(wstride), .dstride(dstride), .zz_sh(zz_sh), .zz_offw(zz_offw),
    .zz_offd(zz_offd), .zz_step(zz_step), .zz_clr(zz_clr), .busy(busy), .done(done),
    .err(err), .waddr(waddr), .daddr(daddr), .addr_vld(addr_vld), .acc_clr(acc_clr),
    .acc_last(acc_last), .acc_sh(acc_sh)
  );

  always #5 clk = ~clk;

  // {busy, done, zz_step, zz_clr, addr_vld, acc_clr, acc_last, acc_sh}
  logic [7:0] obs;
  assign obs = {busy, done, zz_step, zz_clr, addr_vld, acc_clr, acc_last, acc_sh};

  typedef struct {
    logic        st;
    logic [7:0]  exp;
    logic        chk_addr;
    logic [20:0] ew;
    logic [20:0] ed;
  } vec_t;

  vec_t nom [16];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Advance one cycle: drive inputs just after the edge, return at the falling edge.
  task automatic tick(input logic st, input logic stl, input logic ab);
    @(posedge clk);
    #1;
    start = st;
    stall = stl;
    abort = ab;
    cyc++;
    zz_offw = cyc[3:0];
    zz_offd = ~cyc[3:0];
    zz_sh   = cyc[0];
    @(negedge clk);
  endtask

  task automatic nominal_job();
    pw = 4'd2; pd = 4'd3; ntile = 16'd2;
    wbase = 21'h100; wstride = 21'h10; dbase = 21'h200; dstride = 21'h8;
  endtask

  int steps, done_cyc, clr9, vld6, vld7;
  bit got;

  initial begin
    nom[0]  = '{1'b1, 8'b0000_0000, 1'b0, 21'h0,   21'h0};
    nom[1]  = '{1'b0, 8'b1001_0000, 1'b0, 21'h0,   21'h0};
    nom[2]  = '{1'b0, 8'b1010_0000, 1'b0, 21'h0,   21'h0};
    nom[3]  = '{1'b0, 8'b1010_1100, 1'b1, 21'h102, 21'h20D};
    nom[4]  = '{1'b0, 8'b1010_1001, 1'b0, 21'h0,   21'h0};
    nom[5]  = '{1'b0, 8'b1010_1000, 1'b0, 21'h0,   21'h0};
    nom[6]  = '{1'b0, 8'b1010_1001, 1'b0, 21'h0,   21'h0};
    nom[7]  = '{1'b0, 8'b1011_1000, 1'b0, 21'h0,   21'h0};
    nom[8]  = '{1'b0, 8'b1010_1011, 1'b0, 21'h0,   21'h0};
    nom[9]  = '{1'b0, 8'b1010_1100, 1'b1, 21'h118, 21'h20F};
    nom[10] = '{1'b0, 8'b1010_1001, 1'b0, 21'h0,   21'h0};
    nom[11] = '{1'b0, 8'b1010_1000, 1'b0, 21'h0,   21'h0};
    nom[12] = '{1'b0, 8'b1010_1001, 1'b0, 21'h0,   21'h0};
    nom[13] = '{1'b0, 8'b1011_1000, 1'b0, 21'h0,   21'h0};
    nom[14] = '{1'b0, 8'b0100_1011, 1'b1, 21'h11D, 21'h20A};
    nom[15] = '{1'b0, 8'b0000_0000, 1'b0, 21'h0,   21'h0};

    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", {obs, err}, 9'd0);
    check("reset_waddr", waddr, 21'h0);

    // Nominal job from the table
    nominal_job();
    cyc = -1;
    for (int i = 0; i < 16; i++) begin
      tick(nom[i].st, 1'b0, 1'b0);
      check("nom_strobes", obs, nom[i].exp);
      if (nom[i].chk_addr) begin
        check("nom_waddr", waddr, nom[i].ew);
        check("nom_daddr", daddr, nom[i].ed);
      end
    end

    // Stall at cycles 5-6 stretches the job by two cycles
    cyc = -1; steps = 0; done_cyc = -1; clr9 = 0; vld6 = 1; vld7 = 1;
    for (int c = 0; c < 18; c++) begin
      tick(c == 0, (c == 5) || (c == 6), 1'b0);
      if (zz_step) steps++;
      if (done) done_cyc = cyc;
      if (c == 5) check("stall_no_step", zz_step, 1'b0);
      if (c == 6) vld6 = addr_vld;
      if (c == 7) vld7 = addr_vld;
      if (c == 9) clr9 = zz_clr;
    end
    check("stall_steps", steps, 12);
    check("stall_done_cyc", done_cyc, 16);
    check("stall_vld_gap", {vld6[0], vld7[0]}, 2'b00);
    check("stall_tile_clr", clr9, 1);

    // Abort at cycle 6, then a fresh start at cycle 8
    cyc = -1;
    for (int c = 0; c < 6; c++) tick(c == 0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("abort_cycle", {busy, zz_step, zz_clr, done}, 4'b1010);
    tick(1'b0, 1'b0, 1'b0);
    check("abort_after", {busy, addr_vld, done}, 3'b000);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("abort_restart", {busy, zz_clr}, 2'b11);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      got = done;
    end
    check("abort_restart_done", got, 1'b1);
    tick(1'b0, 1'b0, 1'b0);

    // start during RUN with different parameters is ignored
    cyc = -1; steps = 0; done_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      if (c == 5) pw = 4'd15;
      if (c == 6) pw = 4'd2;
      tick((c == 0) || (c == 5), 1'b0, 1'b0);
      if (zz_step) steps++;
      if (done) done_cyc = cyc;
    end
    check("overlap_steps", steps, 12);
    check("overlap_done_cyc", done_cyc, 14);

    // Rejected job (pd=0), then a valid job clears err
    pd = 4'd0;
    cyc = -1; steps = 0;
    tick(1'b1, 1'b0, 1'b0);
    check("reject_c0", {busy, zz_step}, 2'b00);
    tick(1'b0, 1'b0, 1'b0);
    if (zz_step) steps++;
    check("reject_c1", {err, done, busy, zz_step}, 4'b1100);
    tick(1'b0, 1'b0, 1'b0);
    if (zz_step) steps++;
    check("reject_c2", {err, done}, 2'b10);
    check("reject_no_steps", steps, 0);
    pd = 4'd3; ntile = 16'd1;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("reject_err_clr", {err, busy}, 2'b01);
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      got = done;
    end
    check("reject_next_done", {got, err}, 2'b10);
    tick(1'b0, 1'b0, 1'b0);

    // Address wrap past 2^21
    nominal_job();
    wbase = 21'h1FFFF8;
    cyc = -1;
    for (int c = 0; c < 16; c++) begin
      tick(c == 0, 1'b0, 1'b0);
      if (c == 3) check("wrap_tile0", waddr, 21'h1FFFFA);
      if (c == 9) check("wrap_tile1", waddr, 21'h000010);
    end

    // Asynchronous reset in the middle of RUN
    nominal_job();
    cyc = -1;
    for (int c = 0; c < 6; c++) tick(c == 0, 1'b0, 1'b0);
    check("pre_reset_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outs", {obs, err}, 9'd0);
    check("async_reset_addr", {waddr, daddr}, 42'd0);
    #1 rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check("post_reset_idle", obs, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
